vector_register_file: RTL and testbench
=======================================

VECTOR_REGISTER_FILE -- requirements
Module: vector_register_file

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are named clk and reset.
REQ-002 Parameter LANE_WIDTH SHALL default to 32; it is the bits per lane.
REQ-003 Parameter LANES SHALL default to 4; it is the lanes per register.
REQ-004 Parameter REGISTER_NUMBER SHALL default to 16; it is the register count.
REQ-005 Parameter ADDR_NUMBER SHALL default to 5; it is the address width, and 2^ADDR_NUMBER >= REGISTER_NUMBER is required.
REQ-006 The block SHALL have the following ports, with DW = LANE_WIDTH*LANES:
- clk  in  1  rising-edge clock.
- reset  in  1  async active-low reset.
- clear_req  in  1  start zeroing sweep (level, sampled in IDLE).
- wr_en  in  1  write request.
- wr_lane_mask  in  LANES  per-lane write enable.
- wr_addr  in  ADDR_NUMBER  write register.
- wr_data  in  DW  write data.
- rd_en_1, rd_en_2  in  1  read requests.
- rd_addr_1, rd_addr_2  in  ADDR_NUMBER  read registers.
- rd_data_1, rd_data_2  out  DW  registered read data.
- rd_valid_1, rd_valid_2  out  1  read-data valid strobe.
- rd_err_1, rd_err_2  out  1  out-of-range read strobe.
- busy  out  1  clear sweep in progress.

Function
REQ-007 Lane i of every DW-wide bus SHALL occupy bits [i*LANE_WIDTH +: LANE_WIDTH].
REQ-008 Writes SHALL commit at the rising edge of clk; lanes whose wr_lane_mask bit is 0 SHALL retain their old value.
REQ-009 A write with wr_addr >= REGISTER_NUMBER, or with wr_lane_mask == 0, SHALL change no storage.
REQ-010 Read port k SHALL present data at the rising edge following the edge at which rd_en_k = 1 was sampled (latency 1), with rd_valid_k = 1 for exactly that cycle.
REQ-011 When rd_en_k = 0, rd_data_k SHALL hold its previous value and rd_valid_k SHALL be 0.
REQ-012 When a read and a write to the same in-range address are sampled at the same edge, the read SHALL return wr_data for masked-in lanes and the stored value for the other lanes (write-through bypass).
REQ-013 A read of an address >= REGISTER_NUMBER SHALL return all zeros, with rd_valid_k = 1 and rd_err_k = 1 for one cycle.
REQ-014 Both read ports SHALL operate independently; equal addresses on the two ports are legal and return identical data.
REQ-015 The controller SHALL have two states, IDLE and CLEAR, and a pointer clr_ptr of ADDR_NUMBER bits.
REQ-016 In CLEAR, each cycle SHALL write zero to all lanes of register clr_ptr and increment clr_ptr.
REQ-017 CLEAR SHALL exit to IDLE at the edge that clears register REGISTER_NUMBER-1, so a full sweep takes exactly REGISTER_NUMBER cycles.
REQ-018 clear_req = 1 in IDLE SHALL enter CLEAR with clr_ptr = 0 at the next edge; clear_req in CLEAR SHALL be ignored (no restart).
REQ-019 busy SHALL be 1 exactly while in the CLEAR state.
REQ-020 While busy = 1, wr_en and rd_en_k SHALL be ignored: no storage change, rd_valid_k = 0, rd_err_k = 0, rd_data_k held.
REQ-021 A request sampled at the edge on which CLEAR exits to IDLE SHALL be ignored; the first accepted request is sampled on the following edge.

Reset
REQ-022 Asserting reset (low) SHALL immediately force: state CLEAR, clr_ptr = 0, busy = 1, rd_data_k = 0, rd_valid_k = 0, rd_err_k = 0.
REQ-023 Storage SHALL NOT be asynchronously reset; it is zeroed by the CLEAR sweep that begins on the first edge after reset deasserts.
REQ-024 Reset asserted mid-sweep or mid-operation SHALL restart the sweep from clr_ptr = 0; any in-flight read SHALL be discarded.

Structure
REQ-025 Package vrf_pkg SHALL hold the default LANE_WIDTH, LANES, REGISTER_NUMBER and ADDR_NUMBER constants and the IDLE/CLEAR state encoding.
REQ-026 The IDLE/CLEAR controller and clr_ptr SHALL reside in sub-module vrf_clear_fsm (outputs: busy, clr_we, clr_addr); storage, bypass and read registers stay in the top module.

Verification
REQ-027 The bench SHALL cover reset: hold reset low for 3 cycles, then release -> busy = 1 for exactly 16 cycles; afterwards reading r0 through r15 returns 0 with rd_valid pulses.
REQ-028 The bench SHALL cover masked writes: write r3 = 0x44444444_33333333_22222222_11111111 with mask 4'b1111, then r3 = 0xAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD with mask 4'b0101 -> reading r3 returns 0x44444444_BBBBBBBB_22222222_DDDDDDDD.
REQ-029 The bench SHALL cover bypass: at the same edge, write r7 (mask 4'b0011, data 0x...0000_0009_0000_0008) and read r7 on both ports, with prior r7 = 0x...0005_0004_0003_0002 -> both ports return 0x...0005_0004_0009_0008.
REQ-030 The bench SHALL cover out-of-range access: read address 20, and write address 20 followed by a full sweep of reads -> the read returns 0 with rd_err = 1 and rd_valid = 1; no register changes.
REQ-031 The bench SHALL cover clear: write r0..r15 nonzero, pulse clear_req, issue writes and reads during busy -> reads give no rd_valid, writes are ignored, all registers read 0 afterward.
REQ-032 The bench SHALL cover reset mid-sweep: assert reset at sweep cycle 8 -> busy stays 1, and the sweep restarts with 16 full cycles after release.

Source files
------------

// File: rtl/vrf_pkg.sv
// Shared constants and controller state encoding for the vector register file.
package vrf_pkg;

  localparam int VRF_LANE_WIDTH      = 32;
  localparam int VRF_LANES           = 4;
  localparam int VRF_REGISTER_NUMBER = 16;
  localparam int VRF_ADDR_NUMBER     = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } vrf_state_e;

endpackage

// File: rtl/vrf_clear_fsm.sv
// Zeroing-sweep controller: walks clr_ptr over every register, one per cycle,
// and reports busy for the whole sweep.
module vrf_clear_fsm
  import vrf_pkg::*;
#(
  parameter int REGISTER_NUMBER = VRF_REGISTER_NUMBER,
  parameter int ADDR_NUMBER     = VRF_ADDR_NUMBER
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_req,
  output logic                   busy,
  output logic                   clr_we,
  output logic [ADDR_NUMBER-1:0] clr_addr
);

  localparam logic [ADDR_NUMBER-1:0] LAST_PTR = ADDR_NUMBER'(REGISTER_NUMBER - 1);

  vrf_state_e             state_reg, state_next;
  logic [ADDR_NUMBER-1:0] clr_ptr_reg, clr_ptr_next;

  // Reset lands in CLEAR so storage is zeroed without an async reset on the RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= CLEAR;
      clr_ptr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    busy         = 1'b0;
    clr_we       = 1'b0;
    clr_addr     = clr_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (clear_req) begin
          state_next   = CLEAR;
          clr_ptr_next = '0;
        end
      end
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (clr_ptr_reg == LAST_PTR) begin
          state_next   = IDLE;
          clr_ptr_next = '0;
        end else begin
          clr_ptr_next = clr_ptr_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/vector_register_file.sv
// Lane-maskable vector register file: one write port, two registered read
// ports with write-through bypass, and a sweep-based clear.
module vector_register_file
  import vrf_pkg::*;
#(
  parameter int LANE_WIDTH      = VRF_LANE_WIDTH,
  parameter int LANES           = VRF_LANES,
  parameter int REGISTER_NUMBER = VRF_REGISTER_NUMBER,
  parameter int ADDR_NUMBER     = VRF_ADDR_NUMBER
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear_req,
  input  logic                          wr_en,
  input  logic [LANES-1:0]              wr_lane_mask,
  input  logic [ADDR_NUMBER-1:0]        wr_addr,
  input  logic [LANE_WIDTH*LANES-1:0]   wr_data,
  input  logic                          rd_en_1,
  input  logic                          rd_en_2,
  input  logic [ADDR_NUMBER-1:0]        rd_addr_1,
  input  logic [ADDR_NUMBER-1:0]        rd_addr_2,
  output logic [LANE_WIDTH*LANES-1:0]   rd_data_1,
  output logic [LANE_WIDTH*LANES-1:0]   rd_data_2,
  output logic                          rd_valid_1,
  output logic                          rd_valid_2,
  output logic                          rd_err_1,
  output logic                          rd_err_2,
  output logic                          busy
);

  localparam int DW    = LANE_WIDTH * LANES;
  localparam int IDX_W = (REGISTER_NUMBER > 1) ? $clog2(REGISTER_NUMBER) : 1;
  localparam logic [ADDR_NUMBER:0] REG_LIMIT = (ADDR_NUMBER + 1)'(REGISTER_NUMBER);

  logic                   clr_we;
  logic [ADDR_NUMBER-1:0] clr_addr;

  vrf_clear_fsm #(
    .REGISTER_NUMBER(REGISTER_NUMBER),
    .ADDR_NUMBER    (ADDR_NUMBER)
  ) u_clear_fsm (
    .clk      (clk),
    .reset    (reset),
    .clear_req(clear_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic             wr_in_range;
  logic             wr_fire;
  logic [IDX_W-1:0] mem_widx;

  assign wr_in_range = ({1'b0, wr_addr} < REG_LIMIT);
  assign wr_fire     = wr_en & ~busy & wr_in_range & (|wr_lane_mask);
  // The sweep owns the write port whenever it runs; user writes are blocked by busy.
  assign mem_widx    = clr_we ? IDX_W'(clr_addr) : IDX_W'(wr_addr);

  logic [1:0]                  rd_en_v;
  logic [1:0][ADDR_NUMBER-1:0] rd_addr_v;
  logic [1:0]                  rd_in_range;
  logic [1:0]                  bypass_hit;
  logic [1:0][IDX_W-1:0]       rd_idx;
  logic [1:0][DW-1:0]          rd_next;

  assign rd_en_v   = {rd_en_2, rd_en_1};
  assign rd_addr_v = {rd_addr_2, rd_addr_1};

  genvar gi, gj;

  generate
    for (gj = 0; gj < 2; gj++) begin : g_port_ctl
      assign rd_in_range[gj] = ({1'b0, rd_addr_v[gj]} < REG_LIMIT);
      assign bypass_hit[gj]  = wr_fire & (wr_addr == rd_addr_v[gj]);
      assign rd_idx[gj]      = IDX_W'(rd_addr_v[gj]);
    end
  endgenerate

  // One storage array per lane so each lane has its own write enable.
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_WIDTH-1:0] mem [REGISTER_NUMBER];
      logic                  lane_we;
      logic [LANE_WIDTH-1:0] lane_wdata;

      assign lane_we    = clr_we | (wr_fire & wr_lane_mask[gi]);
      assign lane_wdata = clr_we ? '0 : wr_data[gi*LANE_WIDTH +: LANE_WIDTH];

      always_ff @(posedge clk) begin
        if (lane_we) begin
          mem[mem_widx] <= lane_wdata;
        end
      end

      for (gj = 0; gj < 2; gj++) begin : g_rd_lane
        assign rd_next[gj][gi*LANE_WIDTH +: LANE_WIDTH] =
          !rd_in_range[gj]                        ? '0 :
          (bypass_hit[gj] && wr_lane_mask[gi])    ? wr_data[gi*LANE_WIDTH +: LANE_WIDTH] :
                                                    mem[rd_idx[gj]];
      end
    end
  endgenerate

  generate
    for (gj = 0; gj < 2; gj++) begin : g_rd
      logic [DW-1:0] rd_data_reg;
      logic          rd_valid_reg;
      logic          rd_err_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rd_data_reg  <= '0;
          rd_valid_reg <= 1'b0;
          rd_err_reg   <= 1'b0;
        end else if (!busy && rd_en_v[gj]) begin
          rd_data_reg  <= rd_next[gj];
          rd_valid_reg <= 1'b1;
          rd_err_reg   <= ~rd_in_range[gj];
        end else begin
          rd_valid_reg <= 1'b0;
          rd_err_reg   <= 1'b0;
        end
      end
    end
  endgenerate

  assign rd_data_1  = g_rd[0].rd_data_reg;
  assign rd_data_2  = g_rd[1].rd_data_reg;
  assign rd_valid_1 = g_rd[0].rd_valid_reg;
  assign rd_valid_2 = g_rd[1].rd_valid_reg;
  assign rd_err_1   = g_rd[0].rd_err_reg;
  assign rd_err_2   = g_rd[1].rd_err_reg;

endmodule

// File: tb/tb_vector_register_file.sv
// Randomized self-checking bench for vector_register_file against an array model.
module tb_vector_register_file;

  localparam int LW = 32;
  localparam int LN = 4;
  localparam int RN = 16;
  localparam int AN = 5;
  localparam int DW = LW * LN;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear_req = 1'b0;
  logic          wr_en = 1'b0;
  logic [LN-1:0] wr_lane_mask = '0;
  logic [AN-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en_1 = 1'b0, rd_en_2 = 1'b0;
  logic [AN-1:0] rd_addr_1 = '0, rd_addr_2 = '0;
  logic [DW-1:0] rd_data_1, rd_data_2;
  logic          rd_valid_1, rd_valid_2, rd_err_1, rd_err_2, busy;

  logic [DW-1:0] model [RN];
  int checks = 0;
  int errors = 0;

  vector_register_file dut (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .wr_en(wr_en), .wr_lane_mask(wr_lane_mask), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_1(rd_en_1), .rd_en_2(rd_en_2), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .rd_valid_1(rd_valid_1), .rd_valid_2(rd_valid_2),
    .rd_err_1(rd_err_1), .rd_err_2(rd_err_2), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [LN-1:0] m, input logic [AN-1:0] wa,
                       input logic [DW-1:0] wd, input logic re1, input logic [AN-1:0] a1,
                       input logic re2, input logic [AN-1:0] a2);
    wr_en = we; wr_lane_mask = m; wr_addr = wa; wr_data = wd;
    rd_en_1 = re1; rd_addr_1 = a1; rd_en_2 = re2; rd_addr_2 = a2;
    $display("txn t=%0t clr=%0b we=%0b m=%h wa=%0d wd=%h re1=%0b a1=%0d re2=%0b a2=%0d",
             $time, clear_req, we, m, wa, wd, re1, a1, re2, a2);
  endtask

  task automatic drive_idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  // A write only lands on an in-range register and only on its selected lanes.
  task automatic model_write(input logic [AN-1:0] a, input logic [LN-1:0] m, input logic [DW-1:0] d);
    if (int'(a) < RN) begin
      for (int l = 0; l < LN; l++) begin
        if (m[l]) model[a][l*LW +: LW] = d[l*LW +: LW];
      end
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AN-1:0] a);
    return (int'(a) < RN) ? model[a] : '0;
  endfunction

  task automatic model_zero();
    for (int r = 0; r < RN; r++) model[r] = '0;
  endtask

  function automatic logic [DW-1:0] rand_dw();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic count_busy(input string name);
    int cnt;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt !== RN) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d expected %0d", name, cnt, RN);
    end
  endtask

  task automatic read_all_zero(input string name);
    for (int i = 0; i < RN; i++) begin
      drive(1'b0, '0, '0, '0, 1'b1, AN'(i), 1'b1, AN'(RN - 1 - i));
      tick();
      checks++;
      if (rd_valid_1 !== 1'b1 || rd_valid_2 !== 1'b1 || rd_data_1 !== '0 || rd_data_2 !== '0 ||
          rd_err_1 !== 1'b0 || rd_err_2 !== 1'b0) begin
        errors++;
        $display("FAIL %s r%0d got v=%b%b e=%b%b d1=%h d2=%h expected v=11 e=00 d=0",
                 name, i, rd_valid_1, rd_valid_2, rd_err_1, rd_err_2, rd_data_1, rd_data_2);
      end
    end
    drive_idle();
  endtask

  task automatic test_reset();
    drive_idle();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || rd_valid_1 !== 1'b0 || rd_valid_2 !== 1'b0 || rd_err_1 !== 1'b0 ||
        rd_data_1 !== '0 || rd_data_2 !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b v=%b%b e=%b d1=%h d2=%h expected busy=1 v=00 e=0 d=0",
               busy, rd_valid_1, rd_valid_2, rd_err_1, rd_data_1, rd_data_2);
    end
    repeat (3) tick();
    reset = 1'b1;
    model_zero();
    count_busy("reset_sweep");
    read_all_zero("reset_read");
  endtask

  task automatic test_masked_write();
    logic [DW-1:0] exp_v;
    exp_v = 128'h44444444_BBBBBBBB_22222222_DDDDDDDD;
    drive(1'b1, 4'b1111, 5'd3, 128'h44444444_33333333_22222222_11111111, 1'b0, '0, 1'b0, '0);
    model_write(5'd3, 4'b1111, wr_data);
    tick();
    drive(1'b1, 4'b0101, 5'd3, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, 1'b0, '0, 1'b0, '0);
    model_write(5'd3, 4'b0101, wr_data);
    tick();
    drive(1'b1, 4'b0000, 5'd3, rand_dw(), 1'b0, '0, 1'b0, '0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b1, 5'd3, 1'b1, 5'd3);
    tick();
    checks++;
    if (rd_data_1 !== exp_v || rd_valid_1 !== 1'b1) begin
      errors++;
      $display("FAIL masked_p1 got v=%b d=%h expected v=1 d=%h", rd_valid_1, rd_data_1, exp_v);
    end
    checks++;
    if (rd_data_2 !== model_read(5'd3) || rd_valid_2 !== 1'b1) begin
      errors++;
      $display("FAIL masked_p2 got v=%b d=%h expected v=1 d=%h", rd_valid_2, rd_data_2, model_read(5'd3));
    end
    drive_idle();
    tick();
    checks++;
    if (rd_valid_1 !== 1'b0 || rd_valid_2 !== 1'b0 || rd_data_1 !== exp_v || rd_data_2 !== exp_v) begin
      errors++;
      $display("FAIL read_hold got v=%b%b d1=%h d2=%h expected v=00 d=%h",
               rd_valid_1, rd_valid_2, rd_data_1, rd_data_2, exp_v);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp_v;
    exp_v = 128'h00000005_00000004_00000009_00000008;
    drive(1'b1, 4'b1111, 5'd7, 128'h00000005_00000004_00000003_00000002, 1'b0, '0, 1'b0, '0);
    model_write(5'd7, 4'b1111, wr_data);
    tick();
    drive(1'b1, 4'b0011, 5'd7, 128'h00000000_00000000_00000009_00000008, 1'b1, 5'd7, 1'b1, 5'd7);
    model_write(5'd7, 4'b0011, wr_data);
    tick();
    checks++;
    if (rd_data_1 !== exp_v || rd_data_2 !== exp_v || rd_valid_1 !== 1'b1 || rd_valid_2 !== 1'b1) begin
      errors++;
      $display("FAIL bypass got v=%b%b d1=%h d2=%h expected v=11 d=%h",
               rd_valid_1, rd_valid_2, rd_data_1, rd_data_2, exp_v);
    end
    drive(1'b0, '0, '0, '0, 1'b1, 5'd7, 1'b0, '0);
    tick();
    checks++;
    if (rd_data_1 !== exp_v) begin
      errors++;
      $display("FAIL bypass_stored got %h expected %h", rd_data_1, exp_v);
    end
    drive_idle();
  endtask

  task automatic test_out_of_range();
    drive(1'b0, '0, '0, '0, 1'b1, 5'd20, 1'b1, 5'd31);
    tick();
    checks++;
    if (rd_data_1 !== '0 || rd_data_2 !== '0 || rd_valid_1 !== 1'b1 || rd_valid_2 !== 1'b1 ||
        rd_err_1 !== 1'b1 || rd_err_2 !== 1'b1) begin
      errors++;
      $display("FAIL oor_read got v=%b%b e=%b%b d1=%h d2=%h expected v=11 e=11 d=0",
               rd_valid_1, rd_valid_2, rd_err_1, rd_err_2, rd_data_1, rd_data_2);
    end
    drive_idle();
    tick();
    checks++;
    if (rd_err_1 !== 1'b0 || rd_err_2 !== 1'b0 || rd_valid_1 !== 1'b0) begin
      errors++;
      $display("FAIL oor_strobe got e=%b%b v=%b expected e=00 v=0", rd_err_1, rd_err_2, rd_valid_1);
    end
    drive(1'b1, 4'b1111, 5'd20, rand_dw() | 128'h1, 1'b0, '0, 1'b0, '0);
    model_write(5'd20, 4'b1111, wr_data);
    tick();
    for (int i = 0; i < RN; i++) begin
      drive(1'b0, '0, '0, '0, 1'b1, AN'(i), 1'b1, AN'(RN - 1 - i));
      tick();
      checks++;
      if (rd_data_1 !== model_read(AN'(i)) || rd_data_2 !== model_read(AN'(RN - 1 - i)) ||
          rd_err_1 !== 1'b0) begin
        errors++;
        $display("FAIL oor_write r%0d got d1=%h d2=%h e=%b expected d1=%h d2=%h e=0", i,
                 rd_data_1, rd_data_2, rd_err_1, model_read(AN'(i)), model_read(AN'(RN - 1 - i)));
      end
    end
    drive_idle();
  endtask

  task automatic test_random();
    logic          we, re1, re2;
    logic [LN-1:0] m;
    logic [AN-1:0] wa, a1, a2;
    logic [DW-1:0] wd, exp1, exp2;
    exp1 = '0;
    exp2 = '0;
    for (int n = 0; n < 300; n++) begin
      we  = 1'($urandom_range(0, 1));
      m   = LN'($urandom());
      wa  = AN'($urandom_range(0, 19));
      wd  = rand_dw();
      re1 = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      re2 = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      a1  = ($urandom_range(0, 3) == 0) ? wa : AN'($urandom_range(0, 19));
      a2  = ($urandom_range(0, 3) == 0) ? wa : AN'($urandom_range(0, 19));
      drive(we, m, wa, wd, re1, a1, re2, a2);
      if (we) model_write(wa, m, wd);
      if (re1) exp1 = model_read(a1);
      if (re2) exp2 = model_read(a2);
      tick();
      checks++;
      if (rd_valid_1 !== re1 || rd_data_1 !== exp1 || rd_err_1 !== (re1 && int'(a1) >= RN)) begin
        errors++;
        $display("FAIL random_p1 n=%0d got v=%b e=%b d=%h expected v=%b e=%b d=%h", n,
                 rd_valid_1, rd_err_1, rd_data_1, re1, (re1 && int'(a1) >= RN), exp1);
      end
      checks++;
      if (rd_valid_2 !== re2 || rd_data_2 !== exp2 || rd_err_2 !== (re2 && int'(a2) >= RN)) begin
        errors++;
        $display("FAIL random_p2 n=%0d got v=%b e=%b d=%h expected v=%b e=%b d=%h", n,
                 rd_valid_2, rd_err_2, rd_data_2, re2, (re2 && int'(a2) >= RN), exp2);
      end
    end
    drive_idle();
  endtask

  task automatic test_clear();
    logic [DW-1:0] hold1, hold2;
    int cnt;
    for (int r = 0; r < RN; r++) begin
      drive(1'b1, 4'b1111, AN'(r), rand_dw() | 128'h1, 1'b0, '0, 1'b0, '0);
      model_write(AN'(r), 4'b1111, wr_data);
      tick();
    end
    drive(1'b0, '0, '0, '0, 1'b1, 5'd9, 1'b1, 5'd12);
    hold1 = model_read(5'd9);
    hold2 = model_read(5'd12);
    tick();
    drive_idle();
    clear_req = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_enter got busy=%b expected 1", busy);
    end
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      clear_req = (cnt < 5);
      drive(1'b1, 4'b1111, AN'($urandom_range(0, RN - 1)), rand_dw() | 128'h1,
            1'b1, AN'($urandom_range(0, 19)), 1'b1, AN'($urandom_range(0, 19)));
      tick();
      cnt++;
      checks++;
      if (rd_valid_1 !== 1'b0 || rd_valid_2 !== 1'b0 || rd_err_1 !== 1'b0 || rd_err_2 !== 1'b0 ||
          rd_data_1 !== hold1 || rd_data_2 !== hold2) begin
        errors++;
        $display("FAIL clear_busy c=%0d got v=%b%b e=%b%b d1=%h d2=%h expected v=00 e=00 d1=%h d2=%h",
                 cnt, rd_valid_1, rd_valid_2, rd_err_1, rd_err_2, rd_data_1, rd_data_2, hold1, hold2);
      end
    end
    clear_req = 1'b0;
    drive_idle();
    checks++;
    if (cnt !== RN) begin
      errors++;
      $display("FAIL clear_length got %0d expected %0d", cnt, RN);
    end
    model_zero();
    read_all_zero("clear_read");
  endtask

  task automatic test_reset_mid_sweep();
    drive(1'b1, 4'b1111, 5'd2, 128'hDEADBEEF_0BADF00D_12345678_9ABCDEF0, 1'b0, '0, 1'b0, '0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b1, 5'd2, 1'b0, '0);
    tick();
    drive_idle();
    reset = 1'b0;
    #1;
    checks++;
    if (rd_valid_1 !== 1'b0 || rd_data_1 !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_inflight got v=%b d=%h busy=%b expected v=0 d=0 busy=1",
               rd_valid_1, rd_data_1, busy);
    end
    repeat (2) tick();
    reset = 1'b1;
    count_busy("reset_midop_sweep");
    model_zero();
    drive(1'b1, 4'b1111, 5'd15, rand_dw() | 128'h1, 1'b0, '0, 1'b0, '0);
    tick();
    drive_idle();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (8) tick();
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_midsweep_busy got %b expected 1", busy);
    end
    repeat (2) tick();
    reset = 1'b1;
    count_busy("reset_midsweep_restart");
    read_all_zero("midsweep_read");
  endtask

  initial begin
    model_zero();
    test_reset();
    test_masked_write();
    test_bypass();
    test_out_of_range();
    test_random();
    test_clear();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
